// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: instruction-fetch port, load/store port
// and the Avalon-MM master side. The arbiter binds to the master modport.
// The CPU ports and the memory together bind to the slave modport.

interface mem_bus_arbiter_if;
   // instruction fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   // load/store port
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   // Avalon-MM master
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   modport master (
      input  if_req, if_addr,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      input  avm_readdata, avm_waitrequest,
      output if_gnt, if_rvalid, if_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );

   modport slave (
      output if_req, if_addr,
      output d_req, d_we, d_addr, d_wdata, d_be,
      output avm_readdata, avm_waitrequest,
      input  if_gnt, if_rvalid, if_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon-MM master between the instruction-fetch
// port and the load/store port, with at most one transaction outstanding.
// Optional build macro MEM_ARB_RR_EN: when defined, simultaneous requests are
// granted round-robin using a 1-bit last-grant pointer; when undefined, the
// data port always wins a tie and no pointer register exists.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transaction; requests sampled and arbitrated each edge
// ISSUE_IF | fetch read on the Avalon bus, waiting for waitrequest=0
// ISSUE_D  | load or store on the Avalon bus, waiting for waitrequest=0
// RESP     | one cycle: read data returned to the owner with rvalid

module mem_bus_arbiter (
   input  logic                  clk,
   input  logic                  reset,
   mem_bus_arbiter_if.master     bus,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_IF = 2'd1,
      ISSUE_D  = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;

   // Fields of the transaction in flight, captured when it wins arbitration.
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic        owner_d_q;

   // Last read data returned to each port; held between responses.
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;

   logic        latch_if;
   logic        latch_d;
   logic        issuing;
   logic        accept;
   logic        in_resp;
   logic        pick_d;

`ifdef MEM_ARB_RR_EN
   // 1 = data port was granted last; reset means fetch was last so data wins the first tie.
   logic        last_d_q;

   // Round-robin pointer follows every grant pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b0;
      end else if (bus.if_gnt || bus.d_gnt) begin
         last_d_q <= bus.d_gnt;
      end
   end

   assign pick_d = !last_d_q;
`else
   assign pick_d = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and arbitration; requests only matter in IDLE.
   always_comb begin
      state_d  = state_q;
      latch_if = 1'b0;
      latch_d  = 1'b0;
      issuing  = 1'b0;
      in_resp  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req && (!bus.if_req || pick_d)) begin
               state_d = ISSUE_D;
               latch_d = 1'b1;
            end else if (bus.if_req) begin
               state_d  = ISSUE_IF;
               latch_if = 1'b1;
            end
         end
         ISSUE_IF, ISSUE_D: begin
            issuing = 1'b1;
            if (!bus.avm_waitrequest) begin
               state_d = we_q ? IDLE : RESP;
            end
         end
         RESP: begin
            in_resp = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the winner's fields and the returned read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         owner_d_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (latch_d) begin
            addr_q    <= bus.d_addr;
            wdata_q   <= bus.d_wdata;
            be_q      <= bus.d_be;
            we_q      <= bus.d_we;
            owner_d_q <= 1'b1;
         end else if (latch_if) begin
            addr_q    <= bus.if_addr;
            wdata_q   <= '0;
            be_q      <= 4'hF;
            we_q      <= 1'b0;
            owner_d_q <= 1'b0;
         end
         if (in_resp) begin
            if (owner_d_q) begin
               d_rdata_q <= bus.avm_readdata;
            end else begin
               if_rdata_q <= bus.avm_readdata;
            end
         end
      end
   end

   // Fetches are always word aligned; the low address bits are masked here
   // rather than at capture so the whole request address is registered.
   assign bus.avm_address    = owner_d_q ? addr_q : {addr_q[31:2], 2'b00};
   assign bus.avm_writedata  = wdata_q;
   assign bus.avm_byteenable = be_q;
   assign bus.avm_read       = issuing && !we_q;
   assign bus.avm_write      = issuing && we_q;

   assign accept       = issuing && !bus.avm_waitrequest;
   assign bus.if_gnt   = accept && (state_q == ISSUE_IF);
   assign bus.d_gnt    = accept && (state_q == ISSUE_D);

   assign bus.if_rvalid = in_resp && !owner_d_q;
   assign bus.d_rvalid  = in_resp && owner_d_q;

   // During RESP the owner sees the live bus data; otherwise the held copy.
   assign bus.if_rdata = bus.if_rvalid ? bus.avm_readdata : if_rdata_q;
   assign bus.d_rdata  = bus.d_rvalid  ? bus.avm_readdata : d_rdata_q;

   assign busy = (state_q != IDLE);

endmodule
